tpu_iss: RTL and testbench

TPU_ISS -- requirements
Module: tpu_iss

---
 rtl/tpu_pkg.sv | 28 ++
 rtl/tpu_iss_slot.sv | 58 +++++
 rtl/tpu_iss.sv | 126 ++++++++++++
 tb/tb_tpu_iss.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU issue stage: renamed-instruction layout,
// slot state encoding and the completion counter width.
package tpu_pkg;

  localparam int TPU_INST_WIDTH = 23;

  // Renamed instruction field positions
  localparam int IDX_MSB   = 22;
  localparam int IDX_LSB   = 21;
  localparam int VLD_BIT   = 20;
  localparam int PSRC1_MSB = 19;
  localparam int PSRC1_LSB = 13;
  localparam int PSRC2_MSB = 12;
  localparam int PSRC2_LSB = 6;
  localparam int PDST_MSB  = 5;
  localparam int PDST_LSB  = 0;

  // Countdown width; EXE_LAT is limited to 1..7
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } slot_state_e;

endpackage

// File: rtl/tpu_iss_slot.sv
// One issue-queue slot: tracks IDLE/WAIT/EXEC/DONE and counts down the
// execution latency. A load always wins over issue and completion.
module tpu_iss_slot
  import tpu_pkg::*;
#(
  parameter int EXE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic        vld,
  input  logic        rdy,
  input  logic        issue,
  output slot_state_e state,
  output logic        cmp
);

  slot_state_e      state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Slot state and latency counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: load clears the slot, otherwise walk the lifecycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (ld) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: if (vld && rdy) state_nxt = S_WAIT;
        S_WAIT: if (issue) begin
          state_nxt = S_EXEC;
          cnt_nxt   = CNT_W'(EXE_LAT);
        end
        S_EXEC: if (cnt == '0) state_nxt = S_DONE;
                else           cnt_nxt   = cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Completion pulse on the EXEC-to-DONE cycle, suppressed by a load
  always_comb begin
    cmp = (state == S_EXEC) && (cnt == '0) && !ld;
  end

endmodule

// File: rtl/tpu_iss.sv
// TPU issue stage: per-slot lifecycle tracking, round-robin single issue,
// destination-ready write-back and loop-complete (arch_swt) detection.
// Optional feature macro ISS_PERF_CNT_EN adds saturating issue/stall counters.
module tpu_iss
  import tpu_pkg::*;
#(
  parameter int ISQ_DEPTH        = 4,
  parameter int INST_WIDTH       = 22,
  parameter int ISQ_IDX_BITS_NUM = 2,
  parameter int EXE_LAT          = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [ISQ_DEPTH-1:0]                tpu_inst_rdy,
  input  logic [TPU_INST_WIDTH*ISQ_DEPTH-1:0] tpu_out_flat,
  input  logic [ISQ_DEPTH-1:0]                isq_ld,
  input  logic                                iss_stall,
  output logic                                iss_vld,
  output logic [ISQ_IDX_BITS_NUM-1:0]         iss_slot,
  output logic [TPU_INST_WIDTH-1:0]           iss_inst,
  output logic [ISQ_DEPTH-1:0]                dst_reg_rdy,
  output logic [ISQ_DEPTH-1:0]                dst_rdy_reg_en,
  output logic                                arch_swt
`ifdef ISS_PERF_CNT_EN
  ,
  output logic [15:0]                         perf_iss_cnt,
  output logic [15:0]                         perf_stall_cnt
`endif
);

  if (EXE_LAT < 1 || EXE_LAT > 7) begin : g_bad_lat
    $error("tpu_iss: EXE_LAT must be 1..7");
  end
  if ((1 << ISQ_IDX_BITS_NUM) < ISQ_DEPTH) begin : g_bad_idx
    $error("tpu_iss: ISQ_IDX_BITS_NUM too narrow for ISQ_DEPTH");
  end
  if (INST_WIDTH > TPU_INST_WIDTH) begin : g_bad_iw
    $error("tpu_iss: raw instruction wider than renamed instruction");
  end
  if (IDX_MSB != TPU_INST_WIDTH-1 || IDX_LSB != VLD_BIT+1 || VLD_BIT != PSRC1_MSB+1 ||
      PSRC1_LSB != PSRC2_MSB+1 || PSRC2_LSB != PDST_MSB+1 || PDST_LSB != 0) begin : g_bad_fmt
    $error("tpu_iss: instruction field layout is not contiguous");
  end

  logic [ISQ_DEPTH-1:0][TPU_INST_WIDTH-1:0] raw;
  slot_state_e                             state [ISQ_DEPTH];
  logic [ISQ_DEPTH-1:0] is_wait, is_done, fin, elig, grant, cmp;
  logic [ISQ_IDX_BITS_NUM-1:0] rr_ptr, pick;
  logic                        hit, cplt, cplt_q;

  assign raw = tpu_out_flat;

  for (genvar i = 0; i < ISQ_DEPTH; i++) begin : g_slot
    assign is_wait[i] = (state[i] == S_WAIT);
    assign is_done[i] = (state[i] == S_DONE);
    // An IDLE slot holding no valid instruction counts as finished
    assign fin[i]     = is_done[i] | ((state[i] == S_IDLE) & ~raw[i][VLD_BIT]);
    assign elig[i]    = is_wait[i] & ~isq_ld[i];
    assign grant[i]   = iss_vld && (pick == ISQ_IDX_BITS_NUM'(i));
    // Load clears the ready bit; completion sets it. Silent during reset.
    assign dst_rdy_reg_en[i] = rst_n & (isq_ld[i] | cmp[i]);
    assign dst_reg_rdy[i]    = rst_n & cmp[i];

    tpu_iss_slot #(.EXE_LAT(EXE_LAT)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (isq_ld[i]),
      .vld   (raw[i][VLD_BIT]),
      .rdy   (tpu_inst_rdy[i]),
      .issue (grant[i]),
      .state (state[i]),
      .cmp   (cmp[i])
    );
  end

  // Round-robin search for the first eligible WAIT slot at or after rr_ptr
  always_comb begin : p_arb
    logic [ISQ_IDX_BITS_NUM-1:0] jj;
    pick = '0;
    hit  = 1'b0;
    jj   = '0;
    for (int k = 0; k < ISQ_DEPTH; k++) begin
      jj = ISQ_IDX_BITS_NUM'((int'(rr_ptr) + k) % ISQ_DEPTH);
      if (!hit && elig[jj]) begin
        hit  = 1'b1;
        pick = jj;
      end
    end
  end

  assign iss_vld  = hit & ~iss_stall;
  assign iss_slot = iss_vld ? pick : '0;
  assign iss_inst = iss_vld ? raw[pick] : '0;

  // Pointer moves just past the issued slot; holds on stall or no issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= '0;
    else if (iss_vld) rr_ptr <= (pick == ISQ_IDX_BITS_NUM'(ISQ_DEPTH-1)) ? '0 : pick + 1'b1;
  end

  assign cplt = (&fin) & (|is_done);

  // Remember the loop-complete condition to pulse only on its rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cplt_q <= 1'b0;
    else        cplt_q <= cplt;
  end

  assign arch_swt = cplt & ~cplt_q;

`ifdef ISS_PERF_CNT_EN
  // Saturating counters: issues, and stalled cycles with work waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_iss_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (iss_vld && perf_iss_cnt != 16'hFFFF)
        perf_iss_cnt <= perf_iss_cnt + 1'b1;
      if (iss_stall && (|is_wait) && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_iss.sv
// Scoreboard bench for tpu_iss: expected issues are queued as stimulus is
// driven and popped by a negedge monitor; completion latency is measured
// against the observed issue cycle.
module tb_tpu_iss;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int IW    = 23;

  typedef struct {
    logic [1:0]    slot;
    logic [IW-1:0] inst;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [DEPTH-1:0]            tpu_inst_rdy, isq_ld;
  logic                        iss_stall;
  logic [DEPTH-1:0][IW-1:0]    inst_arr;
  logic [IW*DEPTH-1:0]         tpu_out_flat;
  logic                        iss_vld, arch_swt;
  logic [1:0]                  iss_slot;
  logic [IW-1:0]               iss_inst;
  logic [DEPTH-1:0]            dst_reg_rdy, dst_rdy_reg_en;
`ifdef ISS_PERF_CNT_EN
  logic [15:0]                 perf_iss_cnt, perf_stall_cnt;
`endif

  int   n_chk = 0, n_err = 0, cyc = 0;
  int   pc [DEPTH] = '{default: 0};
  int   iss_cyc [DEPTH] = '{default: 0};
  int   cmp_cyc [DEPTH] = '{default: 0};
  int   arch_cnt = 0, arch_cyc = 0;
  exp_t exp_q [$];
  exp_t mon_e;

  assign tpu_out_flat = inst_arr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tpu_iss #(
    .ISQ_DEPTH(DEPTH), .INST_WIDTH(22), .ISQ_IDX_BITS_NUM(2), .EXE_LAT(LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tpu_inst_rdy   (tpu_inst_rdy),
    .tpu_out_flat   (tpu_out_flat),
    .isq_ld         (isq_ld),
    .iss_stall      (iss_stall),
    .iss_vld        (iss_vld),
    .iss_slot       (iss_slot),
    .iss_inst       (iss_inst),
    .dst_reg_rdy    (dst_reg_rdy),
    .dst_rdy_reg_en (dst_rdy_reg_en),
    .arch_swt       (arch_swt)
`ifdef ISS_PERF_CNT_EN
    ,
    .perf_iss_cnt   (perf_iss_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int s, input logic v, input int salt);
    return {2'(s), v, 7'(salt * 8 + s), 7'(salt * 4 + s + 64), 6'(salt + s * 16)};
  endfunction

  task automatic set_insts(input logic [DEPTH-1:0] vmask, input int salt);
    for (int i = 0; i < DEPTH; i++) inst_arr[i] = mk(i, vmask[i], salt);
  endtask

  task automatic push(input int s);
    exp_t t;
    t.slot = 2'(s);
    t.inst = inst_arr[2'(s)];
    exp_q.push_back(t);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arch(input int n, input int budget);
    int k = 0;
    while (arch_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("arch_wait", 64'(arch_cnt), 64'(n));
  endtask

  task automatic wait_q(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("iss_drain", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_iss(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!iss_vld && k < budget);
    chk("iss_wait", 64'(iss_vld), 1);
  endtask

  // Monitor: scoreboard issues, measure completion latency, count arch_swt
  always @(negedge clk) begin
    if (rst_n) begin
      if (iss_vld) begin
        iss_cyc[iss_slot] = cyc;
        if (exp_q.size() == 0) chk("iss_extra", 64'(iss_vld), 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("iss_slot", 64'(iss_slot), 64'(mon_e.slot));
          chk("iss_inst", 64'(iss_inst), 64'(mon_e.inst));
        end
      end else begin
        chk("iss_idle_zero", 64'({iss_slot, iss_inst}), 0);
      end
      chk("rdy_no_en", 64'(dst_reg_rdy & ~dst_rdy_reg_en), 0);
      for (int i = 0; i < DEPTH; i++) begin
        if (dst_rdy_reg_en[i] && dst_reg_rdy[i]) begin
          pc[i]++;
          chk("cmp_lat", 64'(cyc - iss_cyc[i]), 64'(LAT + 1));
          cmp_cyc[i] = cyc;
        end
      end
      if (arch_swt) begin
        arch_cnt++;
        arch_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with aggressive inputs: outputs must still be quiet
    iss_stall    = 1'b0;
    isq_ld       = '1;
    tpu_inst_rdy = '1;
    set_insts(4'b1111, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 64'({iss_vld, iss_slot, iss_inst, dst_reg_rdy, dst_rdy_reg_en, arch_swt}), 0);

    // All four ready: issue 0,1,2,3 back to back
    push(0); push(1); push(2); push(3);
    tick();
    rst_n  = 1'b1;
    isq_ld = '0;
    wait_arch(1, 40);
    repeat (3) tick();
    chk("s1_consec", 64'(iss_cyc[3] - iss_cyc[0]), 3);
    chk("s1_pulses", 64'({pc[3], pc[2], pc[1], pc[0]}), 64'({32'd1, 32'd1}) | (64'(1) << 32 | 64'(1)));
    chk("s1_arch_after_s3", 64'(arch_cyc - cmp_cyc[3]), 1);
    chk("s1_arch_cnt", 64'(arch_cnt), 1);
`ifdef ISS_PERF_CNT_EN
    chk("s1_perf_iss", 64'(perf_iss_cnt), 4);
`endif

    // Stall three cycles with slots 1 and 2 waiting
    tick();
    isq_ld    = '1;
    iss_stall = 1'b1;
    set_insts(4'b0110, 2);
    @(negedge clk);
    chk("ld_en", 64'(dst_rdy_reg_en), 64'(4'b1111));
    chk("ld_rdy", 64'(dst_reg_rdy), 0);
    tick();
    isq_ld = '0;
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("stall_noiss", 64'(iss_vld), 0);
    end
    tick();
    iss_stall = 1'b0;
    push(1); push(2);
    wait_arch(2, 40);
    chk("s2_order_gap", 64'(iss_cyc[2] - iss_cyc[1]), 1);
`ifdef ISS_PERF_CNT_EN
    chk("s2_perf_stall", 64'(perf_stall_cnt), 3);
    chk("s2_perf_iss", 64'(perf_iss_cnt), 6);
`endif

    // Move pointer to 2 by issuing slot 1 alone
    tick();
    isq_ld = '1;
    set_insts(4'b0010, 3);
    push(1);
    tick();
    isq_ld = '0;
    wait_arch(3, 40);

    // Slots 0 and 3 ready, slot 2 valid but not ready: 3 must go first
    tick();
    isq_ld       = '1;
    tpu_inst_rdy = 4'b1001;
    set_insts(4'b1101, 4);
    push(3); push(0);
    tick();
    isq_ld = '0;
    wait_q(40);
    repeat (6) @(negedge clk);
    chk("s3_pc0", 64'(pc[0]), 2);
    chk("s3_pc3", 64'(pc[3]), 2);
    chk("s3_pc2", 64'(pc[2]), 2);
    chk("s3_arch_blocked", 64'(arch_cnt), 3);

    // Load collides with slot 1 completion
    tick();
    isq_ld       = '1;
    tpu_inst_rdy = '1;
    set_insts(4'b0010, 5);
    push(1);
    tick();
    isq_ld = '0;
    wait_iss(20);
    repeat (3) @(posedge clk);
    #1;
    isq_ld = 4'b0010;
    set_insts(4'b0000, 6);
    @(negedge clk);
    chk("coll_en", 64'(dst_rdy_reg_en), 64'(4'b0010));
    chk("coll_rdy", 64'(dst_reg_rdy), 0);
    tick();
    isq_ld = '0;
    repeat (8) @(negedge clk);
    chk("coll_no_pulse", 64'(pc[1]), 3);
    chk("coll_arch", 64'(arch_cnt), 3);

    // Reset while slot 0 is executing
    tick();
    isq_ld = '1;
    set_insts(4'b0001, 7);
    push(0);
    tick();
    isq_ld = '0;
    wait_iss(20);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    tpu_inst_rdy = '0;
    @(negedge clk);
    chk("rst_mid_out", 64'({iss_vld, iss_slot, iss_inst, dst_reg_rdy, dst_rdy_reg_en, arch_swt}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_no_cmp", 64'(pc[0]), 2);
    chk("rst_arch", 64'(arch_cnt), 3);
`ifdef ISS_PERF_CNT_EN
    chk("rst_perf_iss", 64'(perf_iss_cnt), 0);
`endif
    chk("final_q", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
